// File: rtl/ks_round_key_gen_pkg.sv
// Shared widths, state encoding and round-constant helper for the round-key generator.
package ks_round_key_gen_pkg;

  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int NR_DEF = 32;
  localparam int IW_DEF = 6;
  localparam int ROT_A  = 13;
  localparam int ROT_B  = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Byte j of rc_i is ((4i+j)*7) mod 256; byte 0 is the most significant.
  function automatic logic [WORD_W-1:0] rc_word(input logic [7:0] idx);
    logic [WORD_W-1:0] w;
    logic [7:0]        b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = 8'({idx[5:0], 2'b00} + 8'(j));
      w = {w[WORD_W-9:0], 8'(b * 8'd7)};
    end
    return w;
  endfunction

endpackage

// File: rtl/ks_round_key_gen_if.sv
// Key-stream bundle between the key-schedule stage and the round datapath.
interface ks_round_key_gen_if
  import ks_round_key_gen_pkg::*;
#(
  parameter int IW = IW_DEF
);
  logic              start;
  logic              dec;
  logic [0:KEY_W-1]  key_in;
  logic              busy;
  logic              rkey_valid;
  logic              rkey_ready;
  logic [0:WORD_W-1] rkey;
  logic [IW-1:0]     round_idx;
  logic              done;

  modport master (
    output start, dec, key_in, rkey_ready,
    input  busy, rkey_valid, rkey, round_idx, done
  );

  modport slave (
    input  start, dec, key_in, rkey_ready,
    output busy, rkey_valid, rkey, round_idx, done
  );
endinterface

// File: rtl/ks_round_key_gen_round_fn.sv
// One key-schedule round: rk = K0 ^ L(K1^K2^K3^rc), L(t) = t ^ rotl(t,13) ^ rotl(t,23).
module ks_round_fn
  import ks_round_key_gen_pkg::*;
(
  input  logic [WORD_W-1:0] k0,
  input  logic [WORD_W-1:0] k1,
  input  logic [WORD_W-1:0] k2,
  input  logic [WORD_W-1:0] k3,
  input  logic [WORD_W-1:0] rc,
  output logic [WORD_W-1:0] rk
);
  logic [WORD_W-1:0] t;
  logic [WORD_W-1:0] t_ra;
  logic [WORD_W-1:0] t_rb;

  assign t    = k1 ^ k2 ^ k3 ^ rc;
  assign t_ra = {t[WORD_W-1-ROT_A:0], t[WORD_W-1:WORD_W-ROT_A]};
  assign t_rb = {t[WORD_W-1-ROT_B:0], t[WORD_W-1:WORD_W-ROT_B]};
  assign rk   = k0 ^ t ^ t_ra ^ t_rb;
endmodule

// File: rtl/ks_round_key_gen.sv
// Iterative key schedule: loads a 128-bit key, streams NR round keys on valid/ready.
// Optional reverse (decrypt) order is compiled in with RKEY_REVERSE_EN.
//
// state | meaning
// IDLE  | waiting for start; key and counter load here
// PRE   | reverse only: precompute rk_0..rk_{NR-1} into the buffer
// RUN   | rkey_valid high, advance on each handshake
// FIN   | one-cycle done pulse, then back to IDLE
module ks_round_key_gen
  import ks_round_key_gen_pkg::*;
#(
  parameter int NR = NR_DEF,
  parameter int IW = IW_DEF
)(
  input  logic              clk,
  input  logic              rst,
  ks_round_key_gen_if.slave bus
);
  localparam logic [IW-1:0] LAST = IW'(NR - 1);

  state_t            state;
  logic [WORD_W-1:0] k0, k1, k2, k3;
  logic [WORD_W-1:0] rkey_q;
  logic [IW-1:0]     idx_q;
  logic              busy_q, valid_q, done_q;

  logic [WORD_W-1:0] nk0, nk1, nk2, nk3, nrc, rk_new;
  logic              hs;

  assign hs = valid_q & bus.rkey_ready;

`ifdef RKEY_REVERSE_EN
  localparam int BW = (NR > 2) ? $clog2(NR) : 1;
  logic              rev_q;
  logic [WORD_W-1:0] kbuf [NR];
  logic [IW-1:0]     idx_dn;
  assign idx_dn = idx_q - 1'b1;
`endif

  // The round function always sees the key set that the next registered rkey is built from.
  always_comb begin
    nk0 = k1;
    nk1 = k2;
    nk2 = k3;
    nk3 = rkey_q;
    nrc = rc_word(8'(idx_q) + 8'd1);
    if (state == ST_IDLE) begin
      nk0 = bus.key_in[0:31];
      nk1 = bus.key_in[32:63];
      nk2 = bus.key_in[64:95];
      nk3 = bus.key_in[96:127];
      nrc = rc_word(8'd0);
    end
`ifdef RKEY_REVERSE_EN
    else if (state == ST_PRE) begin
      nk0 = k0;
      nk1 = k1;
      nk2 = k2;
      nk3 = k3;
      nrc = rc_word(8'(idx_q));
    end
`endif
  end

  ks_round_fn u_round_fn (
    .k0 (nk0),
    .k1 (nk1),
    .k2 (nk2),
    .k3 (nk3),
    .rc (nrc),
    .rk (rk_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k0      <= '0;
      k1      <= '0;
      k2      <= '0;
      k3      <= '0;
      rkey_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef RKEY_REVERSE_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            k0     <= nk0;
            k1     <= nk1;
            k2     <= nk2;
            k3     <= nk3;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef RKEY_REVERSE_EN
            rev_q  <= bus.dec;
            if (bus.dec) begin
              state <= ST_PRE;
            end else begin
              rkey_q  <= rk_new;
              valid_q <= 1'b1;
              state   <= ST_RUN;
            end
`else
            rkey_q  <= rk_new;
            valid_q <= 1'b1;
            state   <= ST_RUN;
`endif
          end
        end
`ifdef RKEY_REVERSE_EN
        ST_PRE: begin
          kbuf[idx_q[BW-1:0]] <= rk_new;
          k0 <= k1;
          k1 <= k2;
          k2 <= k3;
          k3 <= rk_new;
          if (idx_q == LAST) begin
            rkey_q  <= rk_new;
            valid_q <= 1'b1;
            state   <= ST_RUN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
`endif
        ST_RUN: begin
          if (hs) begin
`ifdef RKEY_REVERSE_EN
            if (rev_q ? (idx_q == '0) : (idx_q == LAST)) begin
`else
            if (idx_q == LAST) begin
`endif
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= ST_FIN;
            end
`ifdef RKEY_REVERSE_EN
            else if (rev_q) begin
              rkey_q <= kbuf[idx_dn[BW-1:0]];
              idx_q  <= idx_dn;
            end
`endif
            else begin
              k0     <= nk0;
              k1     <= nk1;
              k2     <= nk2;
              k3     <= nk3;
              rkey_q <= rk_new;
              idx_q  <= idx_q + 1'b1;
            end
          end
        end
        ST_FIN: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.rkey_valid = valid_q;
  assign bus.rkey       = rkey_q;
  assign bus.round_idx  = idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_ks_round_key_gen.sv
// Directed self-checking bench for ks_round_key_gen against an independent key-schedule model.
module tb_ks_round_key_gen;
  localparam int NR = 32;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [31:0] exp_q [NR];

  ks_round_key_gen_if #(.IW(IW)) bus ();

  ks_round_key_gen #(.NR(NR), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_rc(input int i);
    logic [31:0] r;
    r = 0;
    for (int j = 0; j < 4; j++) r = (r << 8) | 32'(((4 * i + j) * 7) % 256);
    return r;
  endfunction

  function automatic logic [31:0] m_l(input logic [31:0] t);
    return t ^ ((t << 13) | (t >> 19)) ^ ((t << 23) | (t >> 9));
  endfunction

  task automatic build_exp(input logic [127:0] key);
    logic [31:0] k [4];
    logic [31:0] rk;
    k[0] = key[127:96];
    k[1] = key[95:64];
    k[2] = key[63:32];
    k[3] = key[31:0];
    for (int i = 0; i < NR; i++) begin
      rk = k[0] ^ m_l(k[1] ^ k[2] ^ k[3] ^ m_rc(i));
      exp_q[i] = rk;
      k[0] = k[1];
      k[1] = k[2];
      k[2] = k[3];
      k[3] = rk;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(bus.rkey_valid), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy),       64'd0);
    chk({tag, "_rkey"},  64'(bus.rkey),       64'd0);
    chk({tag, "_idx"},   64'(bus.round_idx),  64'd0);
    chk({tag, "_done"},  64'(bus.done),       64'd0);
  endtask

  // evt_kind: 0 none, 1 start pulse with alt_key at round evt_at, 2 reset at round evt_at
  task automatic run_stream(input string tag, input logic [127:0] key, input logic d,
                            input bit gated, input int evt_at, input int evt_kind,
                            input logic [127:0] alt_key);
    int n, cyc, ei;
    bit fired, rev;
    build_exp(key);
    bus.start = 1'b1;
    bus.key_in = key;
    bus.dec = d;
    tick();
    bus.start = 1'b0;
    bus.dec = 1'b0;
    rev = 1'b0;
`ifdef RKEY_REVERSE_EN
    rev = d;
    if (d) begin
      for (int i = 0; i < NR; i++) begin
        chk({tag, "_pre_busy"},  64'(bus.busy),       64'd1);
        chk({tag, "_pre_valid"}, 64'(bus.rkey_valid), 64'd0);
        tick();
      end
    end
`endif
    n = 0;
    cyc = 0;
    fired = 1'b0;
    while (n < NR && cyc < NR * 8) begin
      ei = rev ? (NR - 1 - n) : n;
      chk({tag, "_valid"}, 64'(bus.rkey_valid), 64'd1);
      chk({tag, "_rkey"},  64'(bus.rkey),       64'(exp_q[ei]));
      chk({tag, "_idx"},   64'(bus.round_idx),  64'(ei));
      chk({tag, "_busy"},  64'(bus.busy),       64'd1);
      chk({tag, "_done"},  64'(bus.done),       64'd0);
      if (!fired && n == evt_at && evt_kind == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals({tag, "_midrst"});
        tick();
        chk_reset_vals({tag, "_postrst"});
        return;
      end
      bus.rkey_ready = gated ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (!fired && n == evt_at && evt_kind == 1) begin
        bus.start = 1'b1;
        bus.key_in = alt_key;
        fired = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      if (bus.rkey_ready) n++;
      cyc++;
    end
    if (n < NR) chk({tag, "_timeout"}, 64'(n), 64'(NR));
    bus.rkey_ready = 1'b1;
    chk({tag, "_fin_done"},  64'(bus.done),       64'd1);
    chk({tag, "_fin_valid"}, 64'(bus.rkey_valid), 64'd0);
    chk({tag, "_fin_busy"},  64'(bus.busy),       64'd0);
    tick();
    chk({tag, "_post_done"},  64'(bus.done),       64'd0);
    chk({tag, "_post_valid"}, 64'(bus.rkey_valid), 64'd0);
    chk({tag, "_post_busy"},  64'(bus.busy),       64'd0);
  endtask

  initial begin
    logic [127:0] bp_key;
    logic [127:0] alt_key;
    bp_key  = 128'h0123456789ABCDEFFEDCBA9876543210;
    alt_key = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    bus.start = 1'b0;
    bus.dec = 1'b0;
    bus.key_in = '0;
    bus.rkey_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) chk_reset_vals("idle");

    // zero key first round key is L(32'h00070E15) = 32'hEB45AD92
    bus.start = 1'b1;
    bus.key_in = '0;
    tick();
    bus.start = 1'b0;
    chk("zero_rk0_hand", 64'(bus.rkey), 64'h0000_0000_EB45_AD92);
    chk("zero_idx0",     64'(bus.round_idx), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("zero_rst");

    run_stream("zero_fwd", 128'd0, 1'b0, 1'b0, -1, 0, '0);
    run_stream("bp_ungated", bp_key, 1'b0, 1'b0, -1, 0, '0);
    run_stream("bp_gated", bp_key, 1'b0, 1'b1, -1, 0, '0);
    run_stream("start_busy", bp_key, 1'b0, 1'b0, 5, 1, alt_key);
    run_stream("rst_mid", bp_key, 1'b0, 1'b1, 10, 2, '0);
    run_stream("after_rst", alt_key, 1'b0, 1'b0, -1, 0, '0);
    run_stream("dec1", bp_key, 1'b1, 1'b0, -1, 0, '0);
    run_stream("dec1_gated", bp_key, 1'b1, 1'b1, -1, 0, '0);
    run_stream("dec0", bp_key, 1'b0, 1'b0, -1, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
